// File: rtl/sop_block_stats.sv
`default_nettype none
// ============================================================================
// Module      : sop_block_stats
// Description : Block statistics for the 4-tap sum-of-products result stream.
//               Valid samples are grouped into blocks of BLOCK_LEN. Each
//               completed block produces its sum, maximum, minimum and
//               truncated mean. The result is held in a single-entry
//               valid/ready output register. A block that completes while
//               that register is still occupied (and not being drained in
//               the same cycle) is discarded and flagged with a one-cycle
//               out_drop pulse.
//
// Ports:
//   CLK        in   1                clock, all state on the rising edge
//   RESET      in   1                synchronous active-high reset
//   in_valid   in   1                in_data carries a sample this cycle
//   in_data    in   WIDTH            unsigned sample
//   out_valid  out  1                result register holds an undelivered block
//   out_ready  in   1                consumer takes the result this cycle
//   out_sum    out  WIDTH+LOG2_LEN   sum of the block's samples
//   out_max    out  WIDTH            largest sample of the block
//   out_min    out  WIDTH            smallest sample of the block
//   out_avg    out  WIDTH            out_sum >> LOG2_LEN
//   out_drop   out  1                pulse: a completed block was discarded
//
// Revision    : 1.0 - initial release
// ============================================================================
module sop_block_stats #(
  parameter int WIDTH     = 10,
  parameter int BLOCK_LEN = 8,
  parameter int LOG2_LEN  = 3
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH+LOG2_LEN-1:0]    out_sum,
  output logic [WIDTH-1:0]             out_max,
  output logic [WIDTH-1:0]             out_min,
  output logic [WIDTH-1:0]             out_avg,
  output logic                         out_drop
);

  // Accumulator width: BLOCK_LEN samples of WIDTH bits cannot exceed this.
  localparam int ACC_W = WIDTH + LOG2_LEN;

  // Sample index of the block's final sample (counter runs 0..BLOCK_LEN-1).
  localparam logic [LOG2_LEN-1:0] C_LAST_IDX = LOG2_LEN'(BLOCK_LEN - 1);
  localparam logic [LOG2_LEN-1:0] C_ONE      = LOG2_LEN'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,   // no samples of the current block held
    S_ACCUM = 1'b1    // 1..BLOCK_LEN-1 samples held
  } state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e               state_q,     state_d;
  logic [LOG2_LEN-1:0]  cnt_q,       cnt_d;
  logic [ACC_W-1:0]     acc_q,       acc_d;
  logic [WIDTH-1:0]     max_q,       max_d;
  logic [WIDTH-1:0]     min_q,       min_d;

  logic                 out_valid_q, out_valid_d;
  logic                 out_drop_q,  out_drop_d;
  logic [ACC_W-1:0]     out_sum_q,   out_sum_d;
  logic [WIDTH-1:0]     out_max_q,   out_max_d;
  logic [WIDTH-1:0]     out_min_q,   out_min_d;
  logic [WIDTH-1:0]     out_avg_q,   out_avg_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [ACC_W-1:0]     in_ext;      // sample zero-extended to accumulator width
  logic [ACC_W-1:0]     merged_sum;  // running sum including this sample
  logic [WIDTH-1:0]     merged_max;
  logic [WIDTH-1:0]     merged_min;
  logic                 block_done;  // this edge accepts the block's last sample
  logic                 slot_free;   // result register can take a new block

  always_comb begin
    in_ext     = {{LOG2_LEN{1'b0}}, in_data};
    merged_sum = acc_q + in_ext;
    merged_max = (in_data > max_q) ? in_data : max_q;
    merged_min = (in_data < min_q) ? in_data : min_q;
    // A pending result that is being drained this cycle frees the slot.
    slot_free  = !out_valid_q || out_ready;
  end

  // --------------------------------------------------------------------------
  // Next-state and output-register logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    max_d       = max_q;
    min_d       = min_q;
    block_done  = 1'b0;

    out_valid_d = out_valid_q;
    out_drop_d  = 1'b0;
    out_sum_d   = out_sum_q;
    out_max_d   = out_max_q;
    out_min_d   = out_min_q;
    out_avg_d   = out_avg_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_ACCUM;
          cnt_d   = C_ONE;
          acc_d   = in_ext;
          max_d   = in_data;
          min_d   = in_data;
        end
      end

      S_ACCUM: begin
        if (in_valid) begin
          if (cnt_q == C_LAST_IDX) begin
            // Final sample: block completes and running state reloads so
            // the next sample starts a fresh block from IDLE.
            block_done = 1'b1;
            state_d    = S_IDLE;
            cnt_d      = '0;
            acc_d      = '0;
            max_d      = '0;
            min_d      = '1;
          end else begin
            cnt_d = cnt_q + C_ONE;
            acc_d = merged_sum;
            max_d = merged_max;
            min_d = merged_min;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        acc_d   = '0;
        max_d   = '0;
        min_d   = '1;
      end
    endcase

    // Result register: completion takes priority over a plain drain, since a
    // drain in the same cycle is exactly what frees the slot for the new block.
    if (block_done) begin
      if (slot_free) begin
        out_valid_d = 1'b1;
        out_sum_d   = merged_sum;
        out_max_d   = merged_max;
        out_min_d   = merged_min;
        out_avg_d   = merged_sum[ACC_W-1:LOG2_LEN];
      end else begin
        // Occupied and not draining: keep the old result, lose the new one.
        out_drop_d  = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      max_q       <= '0;
      min_q       <= '1;
      out_valid_q <= 1'b0;
      out_drop_q  <= 1'b0;
      out_sum_q   <= '0;
      out_max_q   <= '0;
      out_min_q   <= '0;
      out_avg_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      max_q       <= max_d;
      min_q       <= min_d;
      out_valid_q <= out_valid_d;
      out_drop_q  <= out_drop_d;
      out_sum_q   <= out_sum_d;
      out_max_q   <= out_max_d;
      out_min_q   <= out_min_d;
      out_avg_q   <= out_avg_d;
    end
  end

  // All outputs come straight from flops.
  assign out_valid = out_valid_q;
  assign out_drop  = out_drop_q;
  assign out_sum   = out_sum_q;
  assign out_max   = out_max_q;
  assign out_min   = out_min_q;
  assign out_avg   = out_avg_q;

endmodule
`default_nettype wire

// File: tb/tb_sop_block_stats.sv
`default_nettype none
// ============================================================================
// Module      : tb_sop_block_stats
// Description : Directed self-checking bench for sop_block_stats. Inputs are
//               changed and outputs sampled 1 time unit after each rising
//               edge, so every check sees the state the preceding edge made.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sop_block_stats;

  localparam int WIDTH     = 10;
  localparam int BLOCK_LEN = 8;
  localparam int LOG2_LEN  = 3;

  logic                       CLK = 1'b0;
  logic                       RESET;
  logic                       in_valid;
  logic [WIDTH-1:0]           in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH+LOG2_LEN-1:0]  out_sum;
  logic [WIDTH-1:0]           out_max;
  logic [WIDTH-1:0]           out_min;
  logic [WIDTH-1:0]           out_avg;
  logic                       out_drop;

  int n_tests = 0;
  int n_fail  = 0;

  sop_block_stats #(
    .WIDTH     (WIDTH),
    .BLOCK_LEN (BLOCK_LEN),
    .LOG2_LEN  (LOG2_LEN)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_max   (out_max),
    .out_min   (out_min),
    .out_avg   (out_avg),
    .out_drop  (out_drop)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input int s, input int mx,
                              input int mn, input int av);
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " sum"},   32'(out_sum),   32'(s));
    check({tag, " max"},   32'(out_max),   32'(mx));
    check({tag, " min"},   32'(out_min),   32'(mn));
    check({tag, " avg"},   32'(out_avg),   32'(av));
    check({tag, " drop"},  32'(out_drop),  32'd0);
  endtask

  // Present one sample for one edge.
  task automatic sample(input logic [WIDTH-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = 10'd777;   // garbage while idle must be ignored
  endtask

  initial begin
    logic [WIDTH-1:0] mix [8];
    mix = '{10'd100, 10'd3, 10'd500, 10'd7, 10'd250, 10'd1000, 10'd64, 10'd9};

    RESET     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick();
    tick();

    // ---- reset state
    check("rst valid", 32'(out_valid), 32'd0);
    check("rst drop",  32'(out_drop),  32'd0);
    check("rst sum",   32'(out_sum),   32'd0);
    check("rst max",   32'(out_max),   32'd0);
    check("rst min",   32'(out_min),   32'd0);
    check("rst avg",   32'(out_avg),   32'd0);
    RESET = 1'b0;
    tick();

    // ---- 1: samples 1..8 back-to-back, consumer always ready
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(k);
      tick();
      if (k == 7) check("t1 not yet valid", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    check_result("t1", 36, 8, 1, 4);
    tick();
    check("t1 consumed", 32'(out_valid), 32'd0);
    check("t1 hold sum", 32'(out_sum),   32'd36);

    // ---- 2: eight samples of 1023 with gaps carrying garbage data
    for (int k = 0; k < 8; k++) begin
      sample(10'd1023);
      if (k < 7) begin
        check("t2 no early valid", 32'(out_valid), 32'd0);
        tick();
      end
    end
    check_result("t2", 8184, 1023, 1023, 1023);
    tick();
    check("t2 consumed", 32'(out_valid), 32'd0);

    // ---- mixed values: exercises max/min ordering
    for (int k = 0; k < 8; k++) sample(mix[k]);
    check_result("mix", 1933, 1000, 3, 241);
    tick();

    // ---- 3: result A stalled, block B dropped
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) sample(10'd5);
    check_result("t3 A", 40, 5, 5, 5);
    for (int k = 0; k < 7; k++) sample(10'd9);
    check("t3 no early drop", 32'(out_drop), 32'd0);
    sample(10'd9);
    check("t3 drop pulse", 32'(out_drop),  32'd1);
    check("t3 A kept",     32'(out_valid), 32'd1);
    check("t3 A sum kept", 32'(out_sum),   32'd40);
    check("t3 A max kept", 32'(out_max),   32'd5);
    tick();
    check("t3 drop ends",  32'(out_drop),  32'd0);
    check("t3 A still",    32'(out_sum),   32'd40);

    // ---- 4: A drained in the same edge B completes
    for (int k = 0; k < 7; k++) sample(10'd9);
    out_ready = 1'b1;
    sample(10'd9);
    check_result("t4 B", 72, 9, 9, 9);
    tick();
    check("t4 B consumed", 32'(out_valid), 32'd0);

    // ---- 5: partial block lost on reset
    for (int k = 0; k < 5; k++) sample(10'd7);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("t5 rst valid", 32'(out_valid), 32'd0);
    check("t5 rst sum",   32'(out_sum),   32'd0);
    check("t5 rst max",   32'(out_max),   32'd0);
    check("t5 rst avg",   32'(out_avg),   32'd0);
    for (int k = 0; k < 8; k++) sample(10'd2);
    check_result("t5", 16, 2, 2, 2);

    // ---- 6: reset with a stalled result and a completing sample
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) sample(10'd3);
    check("t6 pending", 32'(out_valid), 32'd1);
    RESET    = 1'b1;
    in_valid = 1'b1;
    in_data  = 10'd3;
    tick();
    RESET    = 1'b0;
    in_valid = 1'b0;
    check("t6 rst valid", 32'(out_valid), 32'd0);
    check("t6 rst drop",  32'(out_drop),  32'd0);
    check("t6 rst sum",   32'(out_sum),   32'd0);
    tick();
    check("t6 no drop after", 32'(out_drop), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) sample(10'd4);
    check("t6 cnt cleared", 32'(out_valid), 32'd0);
    sample(10'd4);
    check_result("t6 next", 32, 4, 4, 4);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
